// File: rtl/axi_lite_dmem.sv
// AXI4-Lite slave data memory: word-wide on-chip RAM with byte-strobe writes.
// One transaction at a time; out-of-window accesses return SLVERR.
module axi_lite_dmem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [2:0]            axi_arprot,
  output logic [31:0]           axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [2:0]            axi_awprot,
  input  logic [31:0]           axi_wdata,
  input  logic [3:0]            axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_MEM, RD_RESP, WR_COLLECT, WR_RESP
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;

  logic rd_err;
  logic aw_got, w_got;
  logic [ADDR_WIDTH-1:0] aw_q;
  logic [31:0] wd_q;
  logic [3:0] ws_q;

  logic ar_hs, aw_hs, w_hs, wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr, ar_off, wr_off;
  logic [31:0] wr_data;
  logic [3:0] wr_strb;
  logic [DEPTH_LOG2-1:0] ar_idx, wr_idx;
  logic ar_err, wr_err;
  logic unused_ok;

  assign ar_hs = axi_arvalid & axi_arready;
  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid & axi_wready;

  // A write completes once both halves are held or handshaking now
  assign wr_fire = (state == IDLE || state == WR_COLLECT)
                 & (aw_got | aw_hs) & (w_got | w_hs);

  assign wr_addr = aw_got ? aw_q : axi_awaddr;
  assign wr_data = w_got ? wd_q : axi_wdata;
  assign wr_strb = w_got ? ws_q : axi_wstrb;

  assign ar_off = axi_araddr - BASE_ADDR;
  assign wr_off = wr_addr - BASE_ADDR;
  assign ar_idx = ar_off[DEPTH_LOG2+1:2];
  assign wr_idx = wr_off[DEPTH_LOG2+1:2];
  assign ar_err = |ar_off[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign wr_err = |wr_off[ADDR_WIDTH-1:DEPTH_LOG2+2];

  assign unused_ok = ^{axi_arprot, axi_awprot,
                       ar_off[1:0], wr_off[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    axi_arready = 1'b0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    unique case (state)
      IDLE: begin
        axi_arready = 1'b1;
        axi_awready = !axi_arvalid;
        axi_wready  = !axi_arvalid;
        if (axi_arvalid)      state_nxt = RD_MEM;
        else if (wr_fire)     state_nxt = WR_RESP;
        else if (aw_hs | w_hs) state_nxt = WR_COLLECT;
      end
      RD_MEM: state_nxt = RD_RESP;
      RD_RESP: if (axi_rready) state_nxt = IDLE;
      WR_COLLECT: begin
        axi_awready = !aw_got;
        axi_wready  = !w_got;
        if (wr_fire) state_nxt = WR_RESP;
      end
      WR_RESP: if (axi_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_rvalid <= 1'b0;
      axi_bvalid <= 1'b0;
      axi_rdata  <= '0;
      axi_rresp  <= OKAY;
      axi_bresp  <= OKAY;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      rd_err     <= 1'b0;
      aw_q       <= '0;
      wd_q       <= '0;
      ws_q       <= '0;
    end else begin
      if (ar_hs) rd_err <= ar_err;
      if (state == RD_MEM) begin
        axi_rdata  <= rd_err ? 32'h0 : ram_q;
        axi_rresp  <= rd_err ? SLVERR : OKAY;
        axi_rvalid <= 1'b1;
      end
      if (state == RD_RESP && axi_rready) axi_rvalid <= 1'b0;
      if (aw_hs && !wr_fire) begin
        aw_got <= 1'b1;
        aw_q   <= axi_awaddr;
      end
      if (w_hs && !wr_fire) begin
        w_got <= 1'b1;
        wd_q  <= axi_wdata;
        ws_q  <= axi_wstrb;
      end
      if (wr_fire) begin
        axi_bvalid <= 1'b1;
        axi_bresp  <= wr_err ? SLVERR : OKAY;
      end
      if (state == WR_RESP && axi_bready) begin
        axi_bvalid <= 1'b0;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end
    end
  end

  // RAM holds no reset; read issues on the ar handshake cycle
  always_ff @(posedge clk) begin
    if (ar_hs) ram_q <= mem[ar_idx];
    if (wr_fire && !wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_dmem.sv
// Bench for axi_lite_dmem: vector table, corner sequences and
// randomized traffic against an array-based memory model.
module tb_axi_lite_dmem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [2:0]  axi_arprot = '0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [2:0]  axi_awprot = '0;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  localparam int WIN = 4 * 4096;

  axi_lite_dmem dut (
    .clk(clk), .rst(rst),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly,
                          input int w_dly, input int b_dly,
                          input logic [1:0] exp_b);
    bit aw_done = 0;
    bit w_done = 0;
    bit hs_aw, hs_w;
    int cyc = 0;
    axi_awaddr = a;
    axi_wdata = d;
    axi_wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      axi_awvalid = !aw_done && cyc >= aw_dly;
      axi_wvalid = !w_done && cyc >= w_dly;
      @(negedge clk);
      hs_aw = axi_awvalid && axi_awready;
      hs_w = axi_wvalid && axi_wready;
      @(posedge clk); #1;
      aw_done |= hs_aw;
      w_done |= hs_w;
      if (!(aw_done && w_done)) chk("bvalid_early", axi_bvalid, 0);
      cyc++;
    end
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      chk("wr_handshake_timeout", 0, 1);
      return;
    end
    chk("bvalid_rise", axi_bvalid, 1);
    chk("bresp", axi_bresp, exp_b);
    repeat (b_dly) begin
      @(posedge clk); #1;
      chk("bvalid_hold", axi_bvalid, 1);
      chk("bresp_hold", axi_bresp, exp_b);
    end
    axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_bready = 1'b0;
    chk("bvalid_drop", axi_bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input int r_dly);
    bit hs = 0;
    int cyc = 0;
    axi_araddr = a;
    axi_arvalid = 1'b1;
    while (!hs && cyc < 40) begin
      @(negedge clk);
      hs = axi_arvalid && axi_arready;
      @(posedge clk); #1;
      cyc++;
    end
    axi_arvalid = 1'b0;
    if (!hs) begin
      chk("rd_handshake_timeout", 0, 1);
      return;
    end
    chk("rvalid_n1", axi_rvalid, 0);
    @(posedge clk); #1;
    chk("rvalid_n2", axi_rvalid, 1);
    chk("rdata", axi_rdata, exp_d);
    chk("rresp", axi_rresp, exp_r);
    repeat (r_dly) begin
      @(posedge clk); #1;
      chk("rvalid_hold", axi_rvalid, 1);
      chk("rdata_hold", axi_rdata, exp_d);
    end
    axi_rready = 1'b1;
    @(posedge clk); #1;
    axi_rready = 1'b0;
    chk("rvalid_drop", axi_rvalid, 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] raddr;
    logic [1:0]  bexp;
    logic [31:0] rexp;
    logic [1:0]  rrexp;
  } vec_t;

  vec_t tbl[10];
  logic [31:0] mdl[16];

  initial begin
    tbl[0] = '{32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 2'b00, 32'hA5A5A5A5, 2'b00};
    tbl[1] = '{32'h10, 32'hDEADBEEF, 4'hF, 32'h10, 2'b00, 32'hDEADBEEF, 2'b00};
    tbl[2] = '{32'h10, 32'h0000FFFF, 4'h3, 32'h10, 2'b00, 32'hDEADFFFF, 2'b00};
    tbl[3] = '{32'h10, 32'h12345678, 4'h8, 32'h10, 2'b00, 32'h12ADFFFF, 2'b00};
    tbl[4] = '{32'h10, 32'hFFFFFFFF, 4'h0, 32'h10, 2'b00, 32'h12ADFFFF, 2'b00};
    tbl[5] = '{32'h13, 32'hAABBCCDD, 4'h4, 32'h10, 2'b00, 32'h12BBFFFF, 2'b00};
    tbl[6] = '{32'h3FFC, 32'hCAFEF00D, 4'hF, 32'h3FFC, 2'b00, 32'hCAFEF00D, 2'b00};
    tbl[7] = '{32'h4000, 32'h11111111, 4'hF, 32'h0, 2'b10, 32'hA5A5A5A5, 2'b00};
    tbl[8] = '{32'hFFFFFFFC, 32'h22222222, 4'hF, 32'h3FFC, 2'b10, 32'hCAFEF00D, 2'b00};
    tbl[9] = '{32'h4, 32'h00C0FFEE, 4'hF, 32'h6, 2'b00, 32'h00C0FFEE, 2'b00};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", axi_arready, 1);
    chk("rst_awready", axi_awready, 1);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_bresp", axi_bresp, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, 0, tbl[i].bexp);
      do_read(tbl[i].raddr, tbl[i].rexp, tbl[i].rrexp, 0);
    end

    // w ahead of aw, then b and r backpressure
    do_write(32'h20, 32'h1, 4'hF, 3, 0, 5, 2'b00);
    do_read(32'h20, 32'h1, 2'b00, 4);
    do_write(32'h24, 32'h77665544, 4'hF, 0, 2, 1, 2'b00);
    do_read(32'h24, 32'h77665544, 2'b00, 0);

    // out-of-window read
    do_read(32'h4000, 32'h0, 2'b10, 2);
    do_read(32'h0, 32'hA5A5A5A5, 2'b00, 0);

    // reset while the read sits in RD_MEM
    axi_araddr = 32'h10;
    axi_arvalid = 1'b1;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t1_rvalid", axi_rvalid, 0);
    chk("t1_bvalid", axi_bvalid, 0);
    chk("t1_arready", axi_arready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t1_rvalid_after", axi_rvalid, 0);

    // contention: read wins, write follows
    do_write(32'h40, 32'h0BADF00D, 4'hF, 0, 0, 0, 2'b00);
    axi_araddr = 32'h40;
    axi_arvalid = 1'b1;
    axi_awaddr = 32'h40;
    axi_awvalid = 1'b1;
    axi_wdata = 32'h600DCAFE;
    axi_wstrb = 4'hF;
    axi_wvalid = 1'b1;
    @(negedge clk);
    chk("t6_arready", axi_arready, 1);
    chk("t6_awready", axi_awready, 0);
    chk("t6_wready", axi_wready, 0);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    @(negedge clk);
    chk("t6_awready_rdmem", axi_awready, 0);
    @(posedge clk); #1;
    chk("t6_rvalid", axi_rvalid, 1);
    chk("t6_rdata_old", axi_rdata, 32'h0BADF00D);
    chk("t6_bvalid_early", axi_bvalid, 0);
    axi_rready = 1'b1;
    @(negedge clk);
    chk("t6_awready_rresp", axi_awready, 0);
    @(posedge clk); #1;
    axi_rready = 1'b0;
    chk("t6_rvalid_drop", axi_rvalid, 0);
    @(negedge clk);
    chk("t6_awready_idle", axi_awready, 1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    chk("t6_bvalid", axi_bvalid, 1);
    chk("t6_bresp", axi_bresp, 2'b00);
    axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_bready = 1'b0;
    chk("t6_bvalid_drop", axi_bvalid, 0);
    do_read(32'h40, 32'h600DCAFE, 2'b00, 0);

    // randomized traffic against word-array model
    for (int w = 0; w < 16; w++) begin
      mdl[w] = $urandom;
      do_write(32'(w * 4), mdl[w], 4'hF, 0, 0, 0, 2'b00);
    end
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a, d;
      logic [3:0] s;
      int wi;
      bit oow;
      oow = ($urandom_range(0, 7) == 0);
      wi = $urandom_range(0, 15);
      if (oow) a = ($urandom_range(0, 1) == 0) ? 32'(WIN + wi * 4) : 32'hFFFFFFF0;
      else a = 32'(wi * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), oow ? 2'b10 : 2'b00);
        if (!oow) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) mdl[wi][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        do_read(a, oow ? 32'h0 : mdl[wi], oow ? 2'b10 : 2'b00,
                $urandom_range(0, 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
